i2s_rx_master: RTL and testbench
================================

// Module: i2s_rx_master
// PURPOSE
// - I2S bus master receiver: generates sck/ws from the system clock and captures serial mic data on sdi.
// - Samples are packed right-justified into 32-bit words and written to an internal FIFO.
// - The host drains the FIFO through a simple read strobe; level flags support threshold interrupts.
// - Sits between an external I2S microphone and a bus-register wrapper.
// PARAMETERS
// - FIFO_AW   4   FIFO address width; depth = 2**FIFO_AW = 16 words (fifo_level range 0..16)
// PORTS
// - clk                   in   1   system clock; all logic on posedge
// - rst_n                 in   1   asynchronous, active-low reset
// - sdi                   in   1   serial data from mic
// - sdo                   out  1   reserved transmit line; driven constant 0
// - ws                    out  1   word select: 0 = left, 1 = right
// - sck                   out  1   serial bit clock
// - fifo_rd               in   1   pop strobe, one word per clk it is high
// - fifo_level_threshold  in   5   level threshold
// - fifo_full             out  1   level == 16
// - fifo_level            out  5   words held, 0..16
// - fifo_level_above      out  1   fifo_level > fifo_level_threshold
// - fifo_rdata            out  32  head word (first-word fall-through)
// - sample_size           in   5   bits captured per channel, 1..31
// - sck_prescaler         in   8   sck half-period = sck_prescaler+1 clk cycles
// - channels              in   2   bit0 = capture left, bit1 = capture right
// - en                    in   1   block enable
// BEHAVIOUR
// - Reset: sck=0, ws=0, sdo=0, all counters 0, FIFO empty, fifo_rdata=0, flags 0.
// - Prescaler counter counts 0..sck_prescaler; at terminal count it wraps and sck toggles.
//   sck period = 2*(sck_prescaler+1) clk cycles.
// - Frame: 64 sck cycles, 32 slots per channel.
//   - 5-bit slot counter advances on each sck falling event.
//   - ws toggles on the falling event at which the slot counter wraps 31->0.
// - I2S timing, one-bit delay:
//   - slot 0 of each half-frame is the delay slot;
//   - slots 1..sample_size carry data MSB first;
//   - later slots are ignored.
// - sdi is sampled in the clk cycle where sck rises (internal rise event), shifted left into a 32-bit register.
// - Push: one clk after the rise event that captures slot sample_size.
//   - Push happens only if the current channel is enabled: left when ws=0 and channels[0], right when ws=1 and channels[1].
//   - Word = sample zero-extended to 32 bits, right-justified.
//   - channels=00 captures nothing.
// - FIFO:
//   - push when full: new word dropped, contents unchanged;
//   - pop when empty: ignored, level stays 0;
//   - push and pop in the same cycle when 0 < level < 16: level unchanged, both performed.
// - fifo_rdata equals the oldest word; it is 0 (or don't-care stable) when empty. Pointers wrap modulo 16.
// - fifo_level_above is combinational from level and threshold: threshold 5 asserts at level 6.
// - en=0:
//   - sck, ws forced 0; prescaler, slot counter and shift register cleared;
//   - FIFO contents kept and still readable.
//   - On en 0->1 the frame restarts at left slot 0.
// - Configuration changes mid-frame take effect immediately; a word in progress may be corrupt, with no error flag.
// - Reset asserted mid-operation clears everything immediately, asynchronously.
// TESTING
// - sck_prescaler=4, en=1 -> sck period 10 clk (1 us @ 10 MHz); ws toggles every 320 clk, period 640 clk.
// - sample_size=18, channels=01, mic drives left 18'h2AAAA -> fifo_rdata=32'h0002AAAA; right samples never pushed.
// - channels=11, left 18'h3FFFF, right 18'h00001 -> FIFO holds 32'h0003FFFF then 32'h00000001.
// - threshold=5, no reads -> fifo_level_above rises when level reaches 6; five 1-clk fifo_rd pulses -> level drops by 5, flag clears.
// - No reads for 17 left samples -> fifo_full=1, level=16, 17th sample dropped, head still the 1st sample.
// - Pulse rst_n low mid-frame -> sck=0, ws=0, level=0 at once; after release the first word is complete and correct.

Source files
------------

// File: rtl/i2s_rx_master.sv
// I2S master receiver: derives sck/ws from clk, shifts in sdi with the one-bit I2S delay,
// and pushes right-justified samples into a first-word-fall-through FIFO read by the host.
module i2s_rx_master #(
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sdi,
  output logic               sdo,
  output logic               ws,
  output logic               sck,
  input  logic               fifo_rd,
  input  logic [4:0]         fifo_level_threshold,
  output logic               fifo_full,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               fifo_level_above,
  output logic [31:0]        fifo_rdata,
  input  logic [4:0]         sample_size,
  input  logic [7:0]         sck_prescaler,
  input  logic [1:0]         channels,
  input  logic               en
);

  localparam int DEPTH_INT = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(DEPTH_INT);

  logic [7:0]  presc_q, presc_d;
  logic        sck_q, sck_d;
  logic [4:0]  slot_q, slot_d;
  logic        ws_q, ws_d;
  logic [31:0] shift_q, shift_d;
  logic        push_q, push_d;

  logic tick, rise_ev, fall_ev, chan_en;

  // ">=" keeps the divider from running away if the prescaler is lowered mid-count.
  assign tick    = (presc_q >= sck_prescaler);
  assign rise_ev = en && tick && !sck_q;
  assign fall_ev = en && tick && sck_q;
  assign chan_en = ws_q ? channels[1] : channels[0];

  always_comb begin
    presc_d = presc_q;
    sck_d   = sck_q;
    slot_d  = slot_q;
    ws_d    = ws_q;
    shift_d = shift_q;
    push_d  = 1'b0;
    if (!en) begin
      presc_d = '0;
      sck_d   = 1'b0;
      slot_d  = '0;
      ws_d    = 1'b0;
      shift_d = '0;
    end else begin
      presc_d = tick ? 8'd0 : presc_q + 8'd1;
      if (tick) sck_d = ~sck_q;
      if (fall_ev) begin
        slot_d = slot_q + 5'd1;
        if (slot_q == 5'd31) ws_d = ~ws_q;
      end
      if (rise_ev) begin
        // Slot 0 is the I2S delay slot; the sample starts fresh after it.
        if (slot_q == 5'd0) shift_d = '0;
        else if (slot_q <= sample_size) shift_d = {shift_q[30:0], sdi};
        push_d = (slot_q != 5'd0) && (slot_q == sample_size) && chan_en;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      sck_q   <= 1'b0;
      slot_q  <= '0;
      ws_q    <= 1'b0;
      shift_q <= '0;
      push_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sck_q   <= sck_d;
      slot_q  <= slot_d;
      ws_q    <= ws_d;
      shift_q <= shift_d;
      push_q  <= push_d;
    end
  end

  assign sck = sck_q;
  assign ws  = ws_q;
  assign sdo = 1'b0;

  // Host side: fifo_rdata shows the head word; every clk with fifo_rd high while
  // the FIFO is non-empty consumes it. Pops on empty and pushes on full are ignored.
  logic [31:0]        mem_q [DEPTH_INT];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   level_q, level_d;
  logic [31:0]        word_mask, push_word;
  logic               do_push, do_pop;

  assign word_mask = (32'd1 << sample_size) - 32'd1;
  assign push_word = shift_q & word_mask;
  assign fifo_full = (level_q == DEPTH);
  assign do_push   = push_q && !fifo_full;
  assign do_pop    = fifo_rd && (level_q != '0);

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_word;
  end

  assign fifo_level       = level_q;
  assign fifo_level_above = (level_q > fifo_level_threshold);
  assign fifo_rdata       = (level_q == '0) ? 32'd0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_i2s_rx_master.sv
// Bench for i2s_rx_master: a behavioural mic follows sck, queues the expected FIFO words,
// and scenario tasks pop the FIFO and compare against that queue.
module tb_i2s_rx_master;

  logic        clk = 1'b0;
  logic        rst_n, sdi, sdo, ws, sck, fifo_rd, fifo_full, fifo_level_above, en;
  logic [4:0]  fifo_level_threshold, fifo_level, sample_size;
  logic [31:0] fifo_rdata;
  logic [7:0]  sck_prescaler;
  logic [1:0]  channels;

  int n_pass = 0;
  int n_checks = 0;
  logic [31:0] exp_q[$];

  // mic model state
  int          m_slot = 0;
  logic        m_ws = 1'b0;
  logic        m_prev_sck = 1'b0;
  logic [31:0] m_left_val = '0, m_right_val = '0;
  logic [31:0] fix_left = '0, fix_right = '0;
  bit          rand_left = 1'b0, rand_right = 1'b0;

  i2s_rx_master dut (
    .clk(clk), .rst_n(rst_n), .sdi(sdi), .sdo(sdo), .ws(ws), .sck(sck),
    .fifo_rd(fifo_rd), .fifo_level_threshold(fifo_level_threshold),
    .fifo_full(fifo_full), .fifo_level(fifo_level), .fifo_level_above(fifo_level_above),
    .fifo_rdata(fifo_rdata), .sample_size(sample_size), .sck_prescaler(sck_prescaler),
    .channels(channels), .en(en)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic pick(input logic ch);
    if (!ch) m_left_val  = rand_left  ? $urandom : fix_left;
    else     m_right_val = rand_right ? $urandom : fix_right;
  endtask

  // Mic: presents the next bit after each sck fall, counts its own slots and queues
  // the expected word when it drives the last bit of an enabled channel.
  task automatic mic_task();
    int idx;
    logic [31:0] val, msk;
    forever begin
      @(posedge clk); #1;
      if (!rst_n || !en) begin
        m_slot = 0; m_ws = 1'b0; m_prev_sck = 1'b0; sdi = 1'b0;
        pick(1'b0);
      end else begin
        if (m_prev_sck && !sck) begin
          if (m_slot == 31) begin
            m_slot = 0; m_ws = ~m_ws; pick(m_ws);
          end else m_slot++;
          val = m_ws ? m_right_val : m_left_val;
          if (m_slot >= 1 && m_slot <= int'(sample_size)) begin
            idx = int'(sample_size) - m_slot;
            sdi = val[idx];
          end else sdi = 1'b0;
          if (m_slot != 0 && m_slot == int'(sample_size) && channels[m_ws]) begin
            msk = (32'd1 << sample_size) - 32'd1;
            exp_q.push_back(val & msk);
          end
        end
        m_prev_sck = sck;
      end
    end
  endtask

  task automatic pop_word(output logic [31:0] w, output bit ok);
    int t = 0;
    while (fifo_level == 0 && t < 4000) begin @(negedge clk); t++; end
    ok = (fifo_level != 0);
    w  = fifo_rdata;
    if (ok) begin fifo_rd = 1'b1; @(negedge clk); fifo_rd = 1'b0; end
  endtask

  task automatic stop_safe();
    int t = 0;
    while (!(m_ws == 1'b0 && m_slot == 2) && t < 3000) begin @(negedge clk); t++; end
    n_checks++;
    if (t >= 3000) $display("FAIL stop_safe: left slot 2 not reached, waited %0d clk", t);
    else n_pass++;
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic configure(input int p, input int sz, input logic [1:0] ch);
    sck_prescaler = 8'(p); sample_size = 5'(sz); channels = ch;
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_checks++; if (sck !== 1'b0) $display("FAIL reset_sck: got %b want 0", sck); else n_pass++;
    n_checks++; if (ws !== 1'b0) $display("FAIL reset_ws: got %b want 0", ws); else n_pass++;
    n_checks++; if (sdo !== 1'b0) $display("FAIL reset_sdo: got %b want 0", sdo); else n_pass++;
    n_checks++; if (fifo_level !== 5'd0) $display("FAIL reset_level: got %0d want 0", fifo_level); else n_pass++;
    n_checks++; if (fifo_rdata !== 32'd0) $display("FAIL reset_rdata: got %h want 0", fifo_rdata); else n_pass++;
    n_checks++; if (fifo_full !== 1'b0 || fifo_level_above !== 1'b0)
      $display("FAIL reset_flags: full=%b above=%b want 0/0", fifo_full, fifo_level_above); else n_pass++;
  endtask

  task automatic test_timing();
    int t, cnt;
    configure(4, 18, 2'b00);
    en = 1'b1;
    t = 0;
    while (sck !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    cnt = 0;
    while (sck === 1'b1 && t < 200) begin @(negedge clk); t++; cnt++; end
    while (sck === 1'b0 && t < 200) begin @(negedge clk); t++; cnt++; end
    n_checks++; if (cnt != 10) $display("FAIL sck_period: got %0d clk want 10", cnt); else n_pass++;
    t = 0;
    while (ws !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    cnt = 0;
    while (ws === 1'b1 && t < 2000) begin @(negedge clk); t++; cnt++; end
    n_checks++; if (cnt != 320) $display("FAIL ws_half_period: got %0d clk want 320", cnt); else n_pass++;
    n_checks++; if (fifo_level !== 5'd0) $display("FAIL ch00_level: got %0d want 0", fifo_level); else n_pass++;
    en = 1'b0;
    @(negedge clk);
    n_checks++; if (sck !== 1'b0 || ws !== 1'b0 || sdo !== 1'b0)
      $display("FAIL disable_outputs: sck=%b ws=%b sdo=%b want 0/0/0", sck, ws, sdo); else n_pass++;
  endtask

  task automatic test_left_only();
    logic [31:0] w, e;
    bit ok;
    fix_left = 32'h2AAAA; rand_left = 1'b0; rand_right = 1'b1;
    configure(1, 18, 2'b01);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pop_word(w, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      n_checks++;
      if (!ok || w !== 32'h0002AAAA || w !== e)
        $display("FAIL left_only_word%0d: got %h (ok=%0b) want %h", i, w, ok, 32'h0002AAAA);
      else n_pass++;
    end
    stop_safe();
    n_checks++;
    if (int'(fifo_level) != exp_q.size())
      $display("FAIL left_only_level: got %0d want %0d", fifo_level, exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0) begin
      pop_word(w, ok); e = exp_q.pop_front(); n_checks++;
      if (!ok || w !== e) $display("FAIL left_only_drain: got %h want %h", w, e); else n_pass++;
    end
  endtask

  task automatic test_stereo();
    logic [31:0] w, e;
    bit ok;
    fix_left = 32'h3FFFF; fix_right = 32'h1; rand_left = 1'b0; rand_right = 1'b0;
    configure(1, 18, 2'b11);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pop_word(w, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      n_checks++;
      if (!ok || w !== e || w !== ((i % 2 == 0) ? 32'h0003FFFF : 32'h00000001))
        $display("FAIL stereo_word%0d: got %h want %h", i, w, e);
      else n_pass++;
    end
    stop_safe();
    while (exp_q.size() > 0) begin
      pop_word(w, ok); e = exp_q.pop_front(); n_checks++;
      if (!ok || w !== e) $display("FAIL stereo_drain: got %h want %h", w, e); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] w, e;
    bit ok;
    rand_left = 1'b1; rand_right = 1'b1;
    for (int k = 0; k < 3; k++) begin
      configure($urandom_range(0, 3), $urandom_range(2, 31), 2'($urandom_range(1, 3)));
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
        pop_word(w, ok);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_checks++;
        if (!ok || w !== e) $display("FAIL random%0d_word%0d: got %h want %h", k, i, w, e); else n_pass++;
      end
      stop_safe();
      while (exp_q.size() > 0) begin
        pop_word(w, ok); e = exp_q.pop_front(); n_checks++;
        if (!ok || w !== e) $display("FAIL random%0d_drain: got %h want %h", k, w, e); else n_pass++;
      end
    end
  endtask

  task automatic test_threshold();
    logic [31:0] w, e;
    bit ok, seen5;
    int t, lvl;
    rand_left = 1'b1;
    fifo_level_threshold = 5'd5;
    configure(1, 16, 2'b01);
    en = 1'b1;
    seen5 = 1'b0; t = 0;
    while (fifo_level < 6 && t < 3000) begin
      if (fifo_level == 5 && !seen5) begin
        seen5 = 1'b1; n_checks++;
        if (fifo_level_above !== 1'b0) $display("FAIL above_at5: got %b want 0", fifo_level_above); else n_pass++;
      end
      @(negedge clk); t++;
    end
    n_checks++;
    if (fifo_level !== 5'd6 || fifo_level_above !== 1'b1)
      $display("FAIL above_at6: level=%0d above=%b want 6/1", fifo_level, fifo_level_above);
    else n_pass++;
    stop_safe();
    lvl = int'(fifo_level);
    n_checks++;
    if (sck !== 1'b0 || ws !== 1'b0 || lvl != exp_q.size())
      $display("FAIL disabled_keep: sck=%b ws=%b level=%0d want 0/0/%0d", sck, ws, lvl, exp_q.size());
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      pop_word(w, ok); e = exp_q.pop_front(); n_checks++;
      if (!ok || w !== e) $display("FAIL thresh_pop%0d: got %h want %h", i, w, e); else n_pass++;
    end
    n_checks++;
    if (int'(fifo_level) != lvl - 5 || fifo_level_above !== 1'b0)
      $display("FAIL thresh_after_pops: level=%0d above=%b want %0d/0", fifo_level, fifo_level_above, lvl - 5);
    else n_pass++;
    while (exp_q.size() > 0) begin
      pop_word(w, ok); e = exp_q.pop_front(); n_checks++;
      if (!ok || w !== e) $display("FAIL thresh_drain: got %h want %h", w, e); else n_pass++;
    end
  endtask

  task automatic test_full();
    logic [31:0] w, e;
    bit ok;
    int t;
    rand_left = 1'b1;
    configure(1, 20, 2'b01);
    en = 1'b1;
    t = 0;
    while (exp_q.size() < 17 && t < 6000) begin @(negedge clk); t++; end
    repeat (20) @(negedge clk);
    stop_safe();
    n_checks++;
    if (exp_q.size() != 17) $display("FAIL full_samples: got %0d want 17", exp_q.size()); else n_pass++;
    n_checks++;
    if (fifo_full !== 1'b1 || fifo_level !== 5'd16)
      $display("FAIL full_flag: full=%b level=%0d want 1/16", fifo_full, fifo_level);
    else n_pass++;
    n_checks++;
    if (exp_q.size() == 0 || fifo_rdata !== exp_q[0])
      $display("FAIL full_head: got %h want first sample", fifo_rdata);
    else n_pass++;
    if (exp_q.size() == 17) void'(exp_q.pop_back());
    while (exp_q.size() > 0) begin
      pop_word(w, ok); e = exp_q.pop_front(); n_checks++;
      if (!ok || w !== e) $display("FAIL full_drain: got %h want %h", w, e); else n_pass++;
    end
    n_checks++;
    if (fifo_level !== 5'd0 || fifo_full !== 1'b0 || fifo_rdata !== 32'd0)
      $display("FAIL empty_after_drain: level=%0d full=%b rdata=%h want 0/0/0", fifo_level, fifo_full, fifo_rdata);
    else n_pass++;
    fifo_rd = 1'b1; @(negedge clk); fifo_rd = 1'b0;
    n_checks++;
    if (fifo_level !== 5'd0) $display("FAIL pop_empty: level=%0d want 0", fifo_level); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] w, e;
    bit ok;
    int t;
    rand_left = 1'b1; rand_right = 1'b1;
    configure(2, 24, 2'b11);
    en = 1'b1;
    t = 0;
    while (!(fifo_level > 0 && sck === 1'b1 && ws === 1'b1) && t < 3000) begin @(negedge clk); t++; end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (sck !== 1'b0 || ws !== 1'b0 || fifo_level !== 5'd0)
      $display("FAIL async_reset: sck=%b ws=%b level=%0d want 0/0/0", sck, ws, fifo_level);
    else n_pass++;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pop_word(w, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      n_checks++;
      if (!ok || w !== e) $display("FAIL post_reset_word%0d: got %h want %h", i, w, e); else n_pass++;
    end
    stop_safe();
    while (exp_q.size() > 0) begin
      pop_word(w, ok); e = exp_q.pop_front(); n_checks++;
      if (!ok || w !== e) $display("FAIL post_reset_drain: got %h want %h", w, e); else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sdi = 1'b0; fifo_rd = 1'b0;
    fifo_level_threshold = 5'd0; sample_size = 5'd18; sck_prescaler = 8'd1; channels = 2'b00;
    fork mic_task(); join_none
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    fifo_level_threshold = 5'd16;
    @(negedge clk);
    test_timing();
    test_left_only();
    test_stereo();
    test_random();
    test_threshold();
    fifo_level_threshold = 5'd16;
    test_full();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
